// File: rtl/lif_pkg.sv
// Shared types and arithmetic helpers for the LIF neuron array.
package lif_pkg;

    typedef enum logic [1:0] {
        LIF_IDLE = 2'd0,
        LIF_RUN  = 2'd1,
        LIF_DONE = 2'd2
    } lif_state_e;

    // Clamp a signed value into the two's complement range of a w-bit word.
    function automatic logic signed [31:0] lif_saturate(input logic signed [31:0] val,
                                                        input int w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 1));
        if (val > hi) begin
            return hi;
        end else if (val < lo) begin
            return lo;
        end
        return val;
    endfunction

endpackage

// File: rtl/lif_update_core.sv
// Combinational single-neuron update: refractory hold, leak toward zero,
// integrate, saturate, threshold fire with subtractive reset.
module lif_update_core
    import lif_pkg::*;
#(
    parameter int WIDTH     = 6,
    parameter int REF_WIDTH = 6
) (
    input  logic signed [WIDTH-1:0]     v_in,
    input  logic signed [WIDTH-1:0]     i_in,
    input  logic signed [WIDTH-1:0]     thr,
    input  logic        [WIDTH-1:0]     decay,
    input  logic        [REF_WIDTH-1:0] refr_in,
    input  logic        [REF_WIDTH-1:0] refr_period,
    output logic signed [WIDTH-1:0]     v_out,
    output logic        [REF_WIDTH-1:0] refr_out,
    output logic                        spike
);

    logic signed [WIDTH:0]   v_x;
    logic signed [WIDTH:0]   d_x;
    logic signed [WIDTH:0]   leak;
    logic signed [WIDTH:0]   sum;
    logic signed [WIDTH:0]   rem;
    logic signed [WIDTH-1:0] vn;

    always_comb begin
        v_x  = {v_in[WIDTH-1], v_in};
        d_x  = {1'b0, decay};
        leak = '0;
        // One extra bit keeps V -/+ decay from wrapping before the zero clamp.
        if (v_x > 0) begin
            leak = v_x - d_x;
            if (leak < 0) leak = '0;
        end else if (v_x < 0) begin
            leak = v_x + d_x;
            if (leak > 0) leak = '0;
        end
        sum = leak + {i_in[WIDTH-1], i_in};
        vn  = WIDTH'(lif_saturate(32'(sum), WIDTH));
        rem = {vn[WIDTH-1], vn} - {thr[WIDTH-1], thr};

        v_out    = v_in;
        refr_out = refr_in;
        spike    = 1'b0;
        if (refr_in != '0) begin
            refr_out = refr_in - REF_WIDTH'(1);
        end else if (vn >= thr) begin
            v_out    = WIDTH'(lif_saturate(32'(rem), WIDTH));
            refr_out = refr_period;
            spike    = 1'b1;
        end else begin
            v_out = vn;
        end
    end

endmodule

// File: rtl/lif_neuron_array.sv
// Time-multiplexed LIF neuron array: one neuron per cycle, spike vector published with done.
// Define LIF_ARRAY_DEBUG_EN to add the dbg_sel / dbg_potential / dbg_refr state read port.
module lif_neuron_array
    import lif_pkg::*;
#(
    parameter  int WIDTH       = 6,
    parameter  int NUM_NEURONS = 4,
    parameter  int REF_WIDTH   = 6,
    localparam int IDX_W       = $clog2(NUM_NEURONS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [NUM_NEURONS*WIDTH-1:0] input_current,
    input  logic [WIDTH-1:0]             threshold,
    input  logic [WIDTH-1:0]             decay,
    input  logic [REF_WIDTH-1:0]         refractory_period,
    output logic                         busy,
    output logic                         done,
    output logic [NUM_NEURONS-1:0]       spike_out
`ifdef LIF_ARRAY_DEBUG_EN
    ,
    input  logic [IDX_W-1:0]             dbg_sel,
    output logic [WIDTH-1:0]             dbg_potential,
    output logic [REF_WIDTH-1:0]         dbg_refr
`endif
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

    lif_state_e                     state_q, state_d;
    logic [IDX_W-1:0]               idx_q, idx_d;
    logic signed [WIDTH-1:0]        potential_q [NUM_NEURONS];
    logic signed [WIDTH-1:0]        potential_d [NUM_NEURONS];
    logic [REF_WIDTH-1:0]           refr_q [NUM_NEURONS];
    logic [REF_WIDTH-1:0]           refr_d [NUM_NEURONS];
    logic [NUM_NEURONS-1:0]         spike_acc_q, spike_acc_d;
    logic [NUM_NEURONS-1:0]         spike_out_q, spike_out_d;

    logic signed [WIDTH-1:0]        core_v;
    logic [REF_WIDTH-1:0]           core_refr;
    logic                           core_spike;

    lif_update_core #(
        .WIDTH     (WIDTH),
        .REF_WIDTH (REF_WIDTH)
    ) u_core (
        .v_in        (potential_q[idx_q]),
        .i_in        (input_current[idx_q*WIDTH +: WIDTH]),
        .thr         (threshold),
        .decay       (decay),
        .refr_in     (refr_q[idx_q]),
        .refr_period (refractory_period),
        .v_out       (core_v),
        .refr_out    (core_refr),
        .spike       (core_spike)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        potential_d = potential_q;
        refr_d      = refr_q;
        spike_acc_d = spike_acc_q;
        spike_out_d = spike_out_q;
        case (state_q)
            LIF_IDLE: begin
                if (start) begin
                    state_d = LIF_RUN;
                    idx_d   = '0;
                end
            end
            LIF_RUN: begin
                potential_d[idx_q] = core_v;
                refr_d[idx_q]      = core_refr;
                spike_acc_d[idx_q] = core_spike;
                // The last neuron's spike joins the published vector on the same edge.
                if (idx_q == LAST_IDX) begin
                    state_d     = LIF_DONE;
                    idx_d       = '0;
                    spike_out_d = spike_acc_d;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            LIF_DONE: state_d = LIF_IDLE;
            default:  state_d = LIF_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= LIF_IDLE;
            idx_q       <= '0;
            spike_acc_q <= '0;
            spike_out_q <= '0;
            for (int i = 0; i < NUM_NEURONS; i++) begin
                potential_q[i] <= '0;
                refr_q[i]      <= '0;
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            spike_acc_q <= spike_acc_d;
            spike_out_q <= spike_out_d;
            potential_q <= potential_d;
            refr_q      <= refr_d;
        end
    end

    assign busy      = (state_q != LIF_IDLE);
    assign done      = (state_q == LIF_DONE);
    assign spike_out = spike_out_q;

`ifdef LIF_ARRAY_DEBUG_EN
    always_comb begin
        dbg_potential = '0;
        dbg_refr      = '0;
        if (int'(dbg_sel) < NUM_NEURONS) begin
            dbg_potential = potential_q[dbg_sel];
            dbg_refr      = refr_q[dbg_sel];
        end
    end
`endif

endmodule

// File: tb/tb_lif_neuron_array.sv
// Directed bench for lif_neuron_array at default parameters; expected spike
// vectors and potentials are worked out by hand from the update rules.
module tb_lif_neuron_array;

    localparam int W = 6;
    localparam int N = 4;
    localparam int R = 6;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [N*W-1:0]   cur;
    logic [W-1:0]     thr;
    logic [W-1:0]     dec;
    logic [R-1:0]     rp;
    logic             busy;
    logic             done;
    logic [N-1:0]     spk;
`ifdef LIF_ARRAY_DEBUG_EN
    logic [1:0]       dbg_sel;
    logic [W-1:0]     dbg_pot;
    logic [R-1:0]     dbg_refr;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    lif_neuron_array dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .input_current     (cur),
        .threshold         (thr),
        .decay             (dec),
        .refractory_period (rp),
        .busy              (busy),
        .done              (done),
        .spike_out         (spk)
`ifdef LIF_ARRAY_DEBUG_EN
        ,
        .dbg_sel           (dbg_sel),
        .dbg_potential     (dbg_pot),
        .dbg_refr          (dbg_refr)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_cur(input int n, input int val);
        cur[n*W +: W] = W'(val);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // One timestep: latency from start edge to done, spike vector, return to idle.
    task automatic run_ts(input string tag, input logic [N-1:0] exp_spk);
        int n;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, " busy"}, 32'(busy), 32'd1);
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, " latency"}, n, N);
        chk({tag, " spikes"}, 32'(spk), 32'(exp_spk));
        @(posedge clk); #1;
        chk({tag, " idle"}, 32'(busy), 32'd0);
    endtask

`ifdef LIF_ARRAY_DEBUG_EN
    task automatic chk_dbg(input string tag, input int n, input int v, input int r);
        dbg_sel = 2'(n);
        #1;
        chk({tag, " dbg_v"}, 32'(dbg_pot), 32'(W'(v)));
        chk({tag, " dbg_r"}, 32'(dbg_refr), 32'(R'(r)));
    endtask
`endif

    initial begin
        int cnt;
        int gap;
        reset = 1'b1;
        start = 1'b0;
        cur   = '0;
        thr   = W'(20);
        dec   = '0;
        rp    = '0;
`ifdef LIF_ARRAY_DEBUG_EN
        dbg_sel = '0;
`endif
        #1;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset spk", 32'(spk), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Quiet network
        run_ts("quiet", 4'b0000);
`ifdef LIF_ARRAY_DEBUG_EN
        for (int i = 0; i < N; i++) chk_dbg("quiet", i, 0, 0);
`endif

        // Integrate and fire on neuron 2: 10, 19, 28->fire (V=8), hold, hold, 17, 26->fire
        set_cur(2, 10); thr = W'(20); dec = W'(1); rp = R'(2);
        run_ts("iaf ts1", 4'b0000);
        run_ts("iaf ts2", 4'b0000);
        run_ts("iaf ts3", 4'b0100);
`ifdef LIF_ARRAY_DEBUG_EN
        chk_dbg("iaf fire", 2, 8, 2);
`endif
        run_ts("iaf ts4", 4'b0000);
        run_ts("iaf ts5", 4'b0000);
        run_ts("iaf ts6", 4'b0000);
        run_ts("iaf ts7", 4'b0100);

        // Saturation on neuron 0: -32 stays -32, then -1, 20, 20+31 clamps to 31 and fires
        pulse_reset();
        cur = '0; set_cur(0, -32); dec = '0; thr = W'(31); rp = '0;
        run_ts("sat ts1", 4'b0000);
        run_ts("sat ts2", 4'b0000);
`ifdef LIF_ARRAY_DEBUG_EN
        chk_dbg("sat floor", 0, -32, 0);
`endif
        set_cur(0, 31);
        run_ts("sat up1", 4'b0000);
        set_cur(0, 21);
        run_ts("sat up2", 4'b0000);
        set_cur(0, 31);
        run_ts("sat clamp", 4'b0001);

        // Leak floor on neuron 1: -5, then -3, -1, 0, 0; a crossing leak would leave -1 here
        pulse_reset();
        cur = '0; set_cur(1, -5); dec = '0; thr = W'(20); rp = '0;
        run_ts("leak preset", 4'b0000);
        cur = '0; dec = W'(2);
        for (int t = 0; t < 4; t++) run_ts("leak step", 4'b0000);
`ifdef LIF_ARRAY_DEBUG_EN
        chk_dbg("leak floor", 1, 0, 0);
`endif
        dec = '0; thr = W'(5); set_cur(1, 5);
        run_ts("leak probe", 4'b0010);
        run_ts("zero refr", 4'b0010);

        // start pulsed mid-RUN is ignored
        pulse_reset();
        cur = '0; thr = W'(20); dec = '0; rp = '0;
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        cnt = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (done === 1'b1) cnt++;
        end
        chk("mid-run start dones", cnt, 1);

        // start held high: one timestep every N+2 cycles
        start = 1'b1;
        cnt = 0;
        while (done !== 1'b1 && cnt < 20) begin @(posedge clk); #1; cnt++; end
        gap = 0;
        do begin @(posedge clk); #1; gap++; end while (done !== 1'b1 && gap < 20);
        chk("back-to-back period", gap, N + 2);
        start = 1'b0;
        repeat (N + 2) @(posedge clk);
        #1 chk("back-to-back idle", 32'(busy), 32'd0);

        // Build non-zero state (V=5 everywhere, refr=3, spike_out=1111), then reset at idx 2
        thr = W'(20); dec = '0; rp = R'(3);
        for (int i = 0; i < N; i++) set_cur(i, 5);
        run_ts("pre ts1", 4'b0000);
        thr = W'(5);
        run_ts("pre ts2", 4'b1111);
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        chk("abort spk", 32'(spk), 32'd0);
`ifdef LIF_ARRAY_DEBUG_EN
        for (int i = 0; i < N; i++) chk_dbg("abort", i, 0, 0);
`endif
        @(posedge clk); #1 reset = 1'b0;
        // Residual V=5 would fire at threshold 1; residual refr would block the second step
        cur = '0; thr = W'(1); rp = '0;
        run_ts("post quiet", 4'b0000);
        for (int i = 0; i < N; i++) set_cur(i, 1);
        run_ts("post fire", 4'b1111);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
